traffic_test: RTL and testbench
===============================

Name: traffic_test

Overview:
- Traffic-light controller for a main street / side street crossing, with a pedestrian walk phase.
- Produces one-hot red/yellow/green lamps per street plus a walk lamp.
- Phase lengths come from three run-time programmable intervals: base, extended and yellow.
- Sits at top level; driven by a car sensor on the side street, a walk button and a reprogramming interface.

Parameters:
- CLKS_PER_SEC, default 1: clock cycles per one-second tick. Synthesis sets the board clock rate; 1 keeps simulation short.
- T_BASE_DEF, default 6: reset value of the base interval, in seconds.
- T_EXT_DEF, default 3: reset value of the extended interval, in seconds.
- T_YEL_DEF, default 2: reset value of the yellow interval, in seconds.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- sensor  in  1  car waiting on side street (level).
- walk_request  in  1  pedestrian button (pulse or level).
- reprogram  in  1  write time_value into the interval chosen by time_param_selector.
- time_param_selector  in  2  00 = base, 01 = extended, 10 = yellow, 11 = none.
- time_value  in  4  new interval value, in seconds (0..15).
- Rm, Ym, Gm  out  1 each  main street red / yellow / green.
- Rs, Ys, Gs  out  1 each  side street red / yellow / green.
- W  out  1  walk lamp.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset=0 resets, operation while reset=1).
- Reset effects:
  - Intervals return to T_BASE_DEF / T_EXT_DEF / T_YEL_DEF.
  - walk_pending is cleared.
  - Tick divider and second counter are cleared.
  - FSM enters MG1.
  - Outputs: Gm=1, Rs=1, all others 0.
- Lamps per state (registered, one lamp per street; W only in WALK):
  - MG1 and MG2: Gm, Rs.
  - MY: Ym, Rs.
  - WALK: Rm, Rs, W.
  - SG and SGX: Rm, Gs.
  - SY: Rm, Ys.
- Timer:
  - Every state entry restarts the tick divider and loads the state's interval T.
  - The state lasts exactly T*CLKS_PER_SEC clocks.
  - An interval value of 0 is treated as 1.
  - Interval registers are sampled at state entry; a change made mid-state takes effect from the next entry.
- Transitions, taken on the last clock of the current interval:
  - MG1 (base): sensor=1 → MY; otherwise → MG2.
  - MG2 (base) → MY. With no traffic, main green therefore lasts 2×base.
  - MY (yellow): walk_pending=1 → WALK; otherwise → SG.
  - WALK (extended) → SG. walk_pending clears on entry to WALK.
  - SG (base): sensor=1 → SGX; otherwise → SY.
  - SGX (extended) → SY.
  - SY (yellow) → MG1.
- sensor is sampled only on the expiry cycle.
- walk_pending:
  - Sets on any clock with walk_request=1, in any state.
  - A request arriving in the same cycle as entry to WALK is served by that WALK phase.
  - Requests arriving during WALK are latched for the next cycle of phases.
- Reprogram:
  - Each clock with reprogram=1 writes time_value to the selected register; selector 11 writes nothing.
  - The FSM is held at the start of MG1 (Gm, Rs, timer cleared); walk_pending is kept.
  - Normal operation resumes, with a fresh MG1, on the first clock after reprogram drops.
- Reset asserted mid-phase: outputs switch to MG1 lamps immediately (asynchronous), regardless of state.

Test Plan:
- CLKS_PER_SEC=1, sensor=0, no walk, after reset release:
  - Gm,Rs for 12 clk, then Ym,Rs 2, then Rm,Gs 6, then Rm,Ys 2; period 22 clk.
- sensor held 1:
  - Gm 6 clk, Ym 2, Gs 9 (6+3), Ys 2; period 19 clk.
- 1-clk walk_request pulse during MG1:
  - after Ym, W=1 with Rm=Rs=1 for 3 clk, then Gs.
  - W stays 0 on the following cycle of phases.
- reprogram=1 for 1 clk with selector=10, time_value=5:
  - MG1 restarts; Ym and Ys phases now last 5 clk.
  - Selector 11 write: timings unchanged.
- Base programmed to 0:
  - MG1, MG2 and SG each last 1 clk.
- reset=0 pulse during SG:
  - Gm=1, Rs=1 at once, all other lamps 0.
  - Intervals back to 6/3/2.
  - Pending walk cleared.

Source files
------------

// File: rtl/traffic_test_if.sv
// Bundle of the street-side signals of the traffic controller: sensor,
// pedestrian button, the reprogramming port and the seven lamps.
interface traffic_test_if;
    logic       sensor;
    logic       walk_request;
    logic       reprogram;
    logic [1:0] time_param_selector;
    logic [3:0] time_value;
    logic       Rm;
    logic       Ym;
    logic       Gm;
    logic       Rs;
    logic       Ys;
    logic       Gs;
    logic       W;

    // The environment drives sensor, button and reprogram inputs and watches the lamps
    modport master (
        output sensor, walk_request, reprogram, time_param_selector, time_value,
        input  Rm, Ym, Gm, Rs, Ys, Gs, W
    );

    // The controller consumes the inputs and owns the lamps
    modport slave (
        input  sensor, walk_request, reprogram, time_param_selector, time_value,
        output Rm, Ym, Gm, Rs, Ys, Gs, W
    );
endinterface

// File: rtl/traffic_test.sv
// Traffic-light controller for a main/side street crossing with a pedestrian
// walk phase. Each phase lasts a programmable number of seconds; a second is
// CLKS_PER_SEC clocks. Lamps are registered and one-hot per street.
module traffic_test #(
    parameter int CLKS_PER_SEC = 1,
    parameter int T_BASE_DEF   = 6,
    parameter int T_EXT_DEF    = 3,
    parameter int T_YEL_DEF    = 2
) (
    input  logic           clk,
    input  logic           reset,
    traffic_test_if.slave  bus
);

    typedef enum logic [2:0] {
        MG1  = 3'd0,
        MG2  = 3'd1,
        MY   = 3'd2,
        WALK = 3'd3,
        SG   = 3'd4,
        SGX  = 3'd5,
        SY   = 3'd6
    } state_t;

    localparam int TICK_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_SEC - 1);

    // Lamp vector order: {Rm, Ym, Gm, Rs, Ys, Gs, W}
    localparam logic [6:0] LAMPS_MG   = 7'b0011000;
    localparam logic [6:0] LAMPS_MY   = 7'b0101000;
    localparam logic [6:0] LAMPS_WALK = 7'b1001001;
    localparam logic [6:0] LAMPS_SG   = 7'b1000010;
    localparam logic [6:0] LAMPS_SY   = 7'b1000100;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
    logic [3:0]        secCnt_q, secCnt_d;
    logic [3:0]        tBase_q, tBase_d;
    logic [3:0]        tExt_q, tExt_d;
    logic [3:0]        tYel_q, tYel_d;
    logic              walkPending_q, walkPending_d;
    logic [6:0]        lamps_q, lamps_d;
    logic              lastClk;

    // The second counter holds "seconds left minus one", so an interval of 0
    // behaves like 1 and the last clock is seen when it reaches zero.
    function automatic logic [3:0] loadVal(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : (v - 4'd1);
    endfunction

    function automatic logic [6:0] lampsOf(input state_t s);
        logic [6:0] l;
        case (s)
            MG1, MG2: l = LAMPS_MG;
            MY:       l = LAMPS_MY;
            WALK:     l = LAMPS_WALK;
            SG, SGX:  l = LAMPS_SG;
            SY:       l = LAMPS_SY;
            default:  l = LAMPS_MG;
        endcase
        return l;
    endfunction

    assign lastClk = (tickCnt_q == TICK_LAST) && (secCnt_q == 4'd0);

    // Next-state logic: reprogramming parks the FSM at a fresh MG1, otherwise
    // the divider counts and the phase advances on its last clock.
    always_comb begin
        tBase_d       = tBase_q;
        tExt_d        = tExt_q;
        tYel_d        = tYel_q;
        state_d       = state_q;
        tickCnt_d     = tickCnt_q;
        secCnt_d      = secCnt_q;
        walkPending_d = walkPending_q | bus.walk_request;

        if (bus.reprogram) begin
            case (bus.time_param_selector)
                2'b00:   tBase_d = bus.time_value;
                2'b01:   tExt_d  = bus.time_value;
                2'b10:   tYel_d  = bus.time_value;
                default: ;
            endcase
            state_d   = MG1;
            tickCnt_d = '0;
            secCnt_d  = loadVal(tBase_d);
        end else if (lastClk) begin
            case (state_q)
                MG1:     state_d = bus.sensor ? MY : MG2;
                MG2:     state_d = MY;
                MY:      state_d = walkPending_q ? WALK : SG;
                WALK:    state_d = SG;
                SG:      state_d = bus.sensor ? SGX : SY;
                SGX:     state_d = SY;
                SY:      state_d = MG1;
                default: state_d = MG1;
            endcase
            tickCnt_d = '0;
            case (state_d)
                MY, SY:    secCnt_d = loadVal(tYel_q);
                WALK, SGX: secCnt_d = loadVal(tExt_q);
                default:   secCnt_d = loadVal(tBase_q);
            endcase
            if (state_d == WALK) begin
                walkPending_d = 1'b0;
            end
        end else if (tickCnt_q == TICK_LAST) begin
            tickCnt_d = '0;
            secCnt_d  = secCnt_q - 4'd1;
        end else begin
            tickCnt_d = tickCnt_q + TICK_W'(1);
        end
    end

    assign lamps_d = lampsOf(state_d);

    // All state, timers, intervals and lamps; reset shows the MG1 lamps at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= MG1;
            tickCnt_q     <= '0;
            secCnt_q      <= loadVal(4'(T_BASE_DEF));
            tBase_q       <= 4'(T_BASE_DEF);
            tExt_q        <= 4'(T_EXT_DEF);
            tYel_q        <= 4'(T_YEL_DEF);
            walkPending_q <= 1'b0;
            lamps_q       <= LAMPS_MG;
        end else begin
            state_q       <= state_d;
            tickCnt_q     <= tickCnt_d;
            secCnt_q      <= secCnt_d;
            tBase_q       <= tBase_d;
            tExt_q        <= tExt_d;
            tYel_q        <= tYel_d;
            walkPending_q <= walkPending_d;
            lamps_q       <= lamps_d;
        end
    end

    assign bus.Rm = lamps_q[6];
    assign bus.Ym = lamps_q[5];
    assign bus.Gm = lamps_q[4];
    assign bus.Rs = lamps_q[3];
    assign bus.Ys = lamps_q[2];
    assign bus.Gs = lamps_q[1];
    assign bus.W  = lamps_q[0];

endmodule

// File: tb/tb_traffic_test.sv
// Bench for the traffic controller: a phase/seconds-remaining reference model
// is stepped every clock and the seven lamps are compared on the falling edge.
module tb_traffic_test;

    localparam int CPS = 1;

    typedef enum {P_MG1, P_MG2, P_MY, P_WALK, P_SG, P_SGX, P_SY} phaseT;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    traffic_test_if tbIf ();

    traffic_test #(
        .CLKS_PER_SEC(CPS),
        .T_BASE_DEF  (6),
        .T_EXT_DEF   (3),
        .T_YEL_DEF   (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tbIf.slave)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: current phase, clocks left in it, intervals, pending walk
    phaseT mPhase;
    int    mRemain;
    int    mBase;
    int    mExt;
    int    mYel;
    bit    mPending;
    logic [6:0] lastLamps;

    function automatic int effSec(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int phaseClocks(input phaseT p);
        case (p)
            P_MY, P_SY:    return effSec(mYel) * CPS;
            P_WALK, P_SGX: return effSec(mExt) * CPS;
            default:       return effSec(mBase) * CPS;
        endcase
    endfunction

    function automatic logic [6:0] expLamps(input phaseT p);
        case (p)
            P_MG1, P_MG2: return 7'b0011000;
            P_MY:         return 7'b0101000;
            P_WALK:       return 7'b1001001;
            P_SG, P_SGX:  return 7'b1000010;
            default:      return 7'b1000100;
        endcase
    endfunction

    function automatic logic [6:0] lampsNow();
        return {tbIf.Rm, tbIf.Ym, tbIf.Gm, tbIf.Rs, tbIf.Ys, tbIf.Gs, tbIf.W};
    endfunction

    task automatic modelReset();
        mBase    = 6;
        mExt     = 3;
        mYel     = 2;
        mPending = 1'b0;
        mPhase   = P_MG1;
        mRemain  = phaseClocks(P_MG1);
    endtask

    task automatic modelStep(input bit sens, input bit req, input bit rep,
                             input logic [1:0] sel, input logic [3:0] val);
        phaseT nxt;
        if (rep) begin
            if (sel == 2'b00) mBase = val;
            if (sel == 2'b01) mExt  = val;
            if (sel == 2'b10) mYel  = val;
            mPhase   = P_MG1;
            mRemain  = phaseClocks(P_MG1);
            mPending = mPending | req;
        end else if (mRemain > 1) begin
            mRemain  = mRemain - 1;
            mPending = mPending | req;
        end else begin
            case (mPhase)
                P_MG1:   nxt = sens ? P_MY : P_MG2;
                P_MG2:   nxt = P_MY;
                P_MY:    nxt = mPending ? P_WALK : P_SG;
                P_WALK:  nxt = P_SG;
                P_SG:    nxt = sens ? P_SGX : P_SY;
                P_SGX:   nxt = P_SY;
                default: nxt = P_MG1;
            endcase
            mPending = (nxt == P_WALK) ? 1'b0 : (mPending | req);
            mPhase   = nxt;
            mRemain  = phaseClocks(nxt);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total = total + 1;
        if (observed !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, step the model at the rising edge, compare lamps at the falling edge
    task automatic applyStimulus(input bit sens, input bit req, input bit rep,
                                 input logic [1:0] sel, input logic [3:0] val);
        tbIf.sensor              = sens;
        tbIf.walk_request        = req;
        tbIf.reprogram           = rep;
        tbIf.time_param_selector = sel;
        tbIf.time_value          = val;
        @(posedge clk);
        modelStep(sens, req, rep, sel, val);
        @(negedge clk);
        lastLamps = lampsNow();
        checkOutput("lamps", {25'd0, lastLamps}, {25'd0, expLamps(mPhase)});
    endtask

    task automatic idleCycle(input bit sens);
        applyStimulus(sens, 1'b0, 1'b0, 2'b11, 4'd0);
    endtask

    task automatic waitPhase(input phaseT target, input int maxCycles);
        int n;
        n = 0;
        while (mPhase != target && n < maxCycles) begin
            idleCycle(1'b0);
            n++;
        end
        checkOutput("waitPhase", {31'd0, lampsNow() == expLamps(target)}, 32'd1);
    endtask

    initial begin
        int cntGm, cntYm, cntGs, cntYs, cntW;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        tbIf.sensor              = 1'b0;
        tbIf.walk_request        = 1'b0;
        tbIf.reprogram           = 1'b0;
        tbIf.time_param_selector = 2'b11;
        tbIf.time_value          = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetLamps", {25'd0, lampsNow()}, 32'h18);
        modelReset();
        reset = 1'b1;

        // Quiet crossing: one 22-clock period
        cntGm = 0; cntYm = 0; cntGs = 0; cntYs = 0;
        for (int i = 0; i < 22; i++) begin
            idleCycle(1'b0);
            cntGm += int'(lastLamps[4]);
            cntYm += int'(lastLamps[5]);
            cntGs += int'(lastLamps[1]);
            cntYs += int'(lastLamps[2]);
        end
        checkOutput("quietGm", cntGm, 12);
        checkOutput("quietYm", cntYm, 2);
        checkOutput("quietGs", cntGs, 6);
        checkOutput("quietYs", cntYs, 2);
        for (int i = 0; i < 22; i++) idleCycle(1'b0);

        // Side traffic always present
        for (int i = 0; i < 40; i++) idleCycle(1'b1);

        // Pedestrian pulse during MG1: exactly one 3-clock walk
        waitPhase(P_MG1, 40);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 4'd0);
        cntW = 0;
        for (int i = 0; i < 50; i++) begin
            idleCycle(1'b0);
            cntW += int'(lastLamps[0]);
        end
        checkOutput("walkCount", cntW, 3);

        // Yellow reprogrammed to 5, then a no-op selector 11 write
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 4'd5);
        cntYm = 0; cntYs = 0;
        for (int i = 0; i < 30; i++) begin
            idleCycle(1'b0);
            cntYm += int'(lastLamps[5]);
            cntYs += int'(lastLamps[2]);
        end
        checkOutput("yel5Ym", cntYm, 5);
        checkOutput("yel5Ys", cntYs, 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 4'd9);
        for (int i = 0; i < 30; i++) idleCycle(1'b0);

        // Base programmed to 0 behaves as one clock
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 4'd0);
        for (int i = 0; i < 30; i++) idleCycle(1'($urandom_range(0, 1)));

        // Asynchronous reset in SG with a walk pending
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 4'd6);
        waitPhase(P_SG, 40);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncReset", {25'd0, lampsNow()}, 32'h18);
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset();
        reset = 1'b1;
        cntW = 0; cntYm = 0;
        for (int i = 0; i < 44; i++) begin
            idleCycle(1'b0);
            cntW  += int'(lastLamps[0]);
            cntYm += int'(lastLamps[5]);
        end
        checkOutput("postResetW", cntW, 0);
        checkOutput("postResetYm", cntYm, 4);

        // Random traffic, buttons and occasional reprogramming
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 29) == 0),
                          2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
